// File: rtl/wb2core.sv
// -----------------------------------------------------------------------------
// wb2core -- Wishbone B4 pipelined slave bridged onto a core-style
// req/gnt/rvalid memory port (the Ibex LSU/fetch handshake). On-chip memories
// and peripherals built for that handshake can then hang off the Wishbone
// interconnect as slaves.
//
// Datapath: one request holding register, an outstanding-transaction counter
// and a registered response stage. A three-state FSM tracks whether a
// Wishbone cycle is running and drains responses still owed to the device
// after the master drops wb_cyc.
//
// Build option:
//   WB2CORE_ERR_EN  defined   -> dev_err returns as wb_err (wb_ack suppressed)
//                   undefined -> wb_err tied low, dev_err ignored, every
//                                forwarded response returns as wb_ack
//
// Parameter:
//   MaxOutstanding  accepted-but-unanswered transactions allowed (1..15)
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   wb_cyc, wb_stb, wb_we          Wishbone cycle / strobe / write enable
//   wb_sel[3:0], wb_adr[31:0]      byte selects, byte address (unmodified)
//   wb_dat_i[31:0]                 write data
//   wb_stall, wb_ack, wb_err       pipelined stall, normal / error termination
//   wb_dat_o[31:0]                 read data (holds when no response)
//   dev_req, dev_gnt               device request (held until grant), grant
//   dev_we, dev_be[3:0]            device write enable, byte enables
//   dev_addr[31:0], dev_wdata      device address, write data
//   dev_rvalid, dev_rdata, dev_err device response strobe, data, error
//   dbg_state_o[1:0]               FSM state (0 IDLE, 1 ACTIVE, 2 DRAIN)
//   dbg_cnt_o[3:0]                 outstanding-transaction count
//
// Handshakes:
//   Wishbone side: a request is taken on any rising edge where
//   wb_cyc & wb_stb & !wb_stall. Device side: dev_req is asserted with stable
//   dev_we/be/addr/wdata and is held until a cycle with dev_gnt high; the
//   request transfers on that edge and is never withdrawn beforehand.
//   dev_rvalid is a one-cycle strobe per granted request, in request order.
// -----------------------------------------------------------------------------
module wb2core #(
  parameter int MaxOutstanding = 2
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_i,
  output logic        wb_stall,
  output logic        wb_ack,
  output logic        wb_err,
  output logic [31:0] wb_dat_o,

  output logic        dev_req,
  input  logic        dev_gnt,
  output logic        dev_we,
  output logic [3:0]  dev_be,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        dev_rvalid,
  input  logic [31:0] dev_rdata,
  input  logic        dev_err,

  output logic [1:0]  dbg_state_o,
  output logic [3:0]  dbg_cnt_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntZero = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            req_valid_q, req_valid_d;
  logic            req_we_q;
  logic [3:0]      req_be_q;
  logic [31:0]     req_addr_q;
  logic [31:0]     req_wdata_q;

  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic accept;     // Wishbone request taken this cycle
  logic rsp_count;  // device response that belongs to a counted transaction
  logic rsp_fwd;    // counted response that is returned to the master
  logic rsp_is_err; // forwarded response terminates with wb_err

`ifdef WB2CORE_ERR_EN
  assign rsp_is_err = dev_err;
`else
  logic unused_dev_err;
  assign unused_dev_err = dev_err;
  assign rsp_is_err     = 1'b0;
`endif

  // The stall term on req_valid_q looks at dev_gnt combinationally, so a
  // request being granted this cycle frees the holding register for the next
  // accept in the same cycle: full throughput with dev_gnt held high. The
  // count term uses the registered count only, so a response arriving in the
  // same cycle never lets an extra request through at the limit.
  always_comb begin
    wb_stall = (req_valid_q & ~dev_gnt) |
               (cnt_q == MaxCnt)        |
               (state_q == ST_DRAIN);
  end

  always_comb begin
    accept    = wb_cyc & wb_stb & ~wb_stall;
    // Responses with nothing outstanding (e.g. owed to requests issued before
    // a reset) are dropped entirely.
    rsp_count = dev_rvalid & (cnt_q != CntZero);
    // After an abort the master no longer expects terminations, so responses
    // are counted but not forwarded.
    rsp_fwd   = rsp_count & (state_q == ST_ACTIVE) & wb_cyc;
  end

  // Outstanding counter.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, rsp_count})
      2'b10:   cnt_d = cnt_q + CntOne;
      2'b01:   cnt_d = cnt_q - CntOne;
      default: cnt_d = cnt_q;
    endcase
  end

  // Holding register valid bit: a grant retires the current request, but an
  // accept in the same cycle reloads it, so the load wins.
  always_comb begin
    req_valid_d = req_valid_q;
    if (accept) begin
      req_valid_d = 1'b1;
    end else if (dev_gnt) begin
      req_valid_d = 1'b0;
    end
  end

  // Response stage: one-cycle termination strobes.
  always_comb begin
    ack_d = rsp_fwd & ~rsp_is_err;
    err_d = rsp_fwd &  rsp_is_err;
  end

  // FSM next state. DRAIN keeps presenting a request that was accepted before
  // the abort until it is granted; only new accepts are blocked (via stall).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!wb_cyc) begin
          state_d = (cnt_d == CntZero) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_d == CntZero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CntZero;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_be_q    <= 4'h0;
      req_addr_q  <= 32'h0;
      req_wdata_q <= 32'h0;
    end else begin
      req_valid_q <= req_valid_d;
      if (accept) begin
        req_we_q    <= wb_we;
        req_be_q    <= wb_sel;
        req_addr_q  <= wb_adr;
        req_wdata_q <= wb_dat_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
      if (rsp_fwd) begin
        rdata_q <= dev_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dev_req     = req_valid_q;
  assign dev_we      = req_we_q;
  assign dev_be      = req_be_q;
  assign dev_addr    = req_addr_q;
  assign dev_wdata   = req_wdata_q;

  assign wb_ack      = ack_q;
  assign wb_err      = err_q;
  assign wb_dat_o    = rdata_q;

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = 4'(cnt_q);

endmodule

// File: tb/tb_wb2core.sv
// -----------------------------------------------------------------------------
// tb_wb2core -- directed self-checking bench for wb2core (MaxOutstanding = 2).
// Inputs are driven 2 time units after each rising edge; outputs are sampled
// one unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_wb2core;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_cyc, wb_stb, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat_i;
  logic        wb_stall, wb_ack, wb_err;
  logic [31:0] wb_dat_o;
  logic        dev_req, dev_gnt, dev_we;
  logic [3:0]  dev_be;
  logic [31:0] dev_addr, dev_wdata;
  logic        dev_rvalid, dev_err;
  logic [31:0] dev_rdata;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_cnt;

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected device write data and expected read data.
  logic [31:0] exp_q[$];
  logic [31:0] rd_q[$];

  wb2core #(.MaxOutstanding(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_we      (wb_we),
    .wb_sel     (wb_sel),
    .wb_adr     (wb_adr),
    .wb_dat_i   (wb_dat_i),
    .wb_stall   (wb_stall),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_dat_o   (wb_dat_o),
    .dev_req    (dev_req),
    .dev_gnt    (dev_gnt),
    .dev_we     (dev_we),
    .dev_be     (dev_be),
    .dev_addr   (dev_addr),
    .dev_wdata  (dev_wdata),
    .dev_rvalid (dev_rvalid),
    .dev_rdata  (dev_rdata),
    .dev_err    (dev_err),
    .dbg_state_o(dbg_state),
    .dbg_cnt_o  (dbg_cnt)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver / checking tasks
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wb_put(input logic we, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat);
    wb_cyc   = 1'b1;
    wb_stb   = 1'b1;
    wb_we    = we;
    wb_sel   = sel;
    wb_adr   = adr;
    wb_dat_i = dat;
  endtask

  task automatic wb_quiet(input logic cyc);
    wb_cyc   = cyc;
    wb_stb   = 1'b0;
    wb_we    = 1'b0;
    wb_sel   = 4'h0;
    wb_adr   = 32'h0;
    wb_dat_i = 32'h0;
  endtask

  task automatic dev_quiet();
    dev_gnt    = 1'b0;
    dev_rvalid = 1'b0;
    dev_rdata  = 32'h0;
    dev_err    = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          acks;
    int          sent;
    int          mcnt;
    logic        mreq;
    logic        rv_prev;
    logic [1:0]  ghist;
    logic        acc;
    logic [31:0] rd_seq;

    rst = 1'b1;
    wb_quiet(1'b0);
    dev_quiet();
    #3;
    // Reset state
    chk("rst_stall", wb_stall, 0);
    chk("rst_ack",   wb_ack,   0);
    chk("rst_req",   dev_req,  0);
    chk("rst_state", dbg_state, S_IDLE);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;

    // ---- Single read ---------------------------------------------------------
    wb_put(1'b0, 4'hF, 32'h100, 32'h0);
    settle();
    chk("sr_stall0", wb_stall, 0);
    chk("sr_req0",   dev_req,  0);
    next_cycle();
    wb_quiet(1'b1); dev_gnt = 1'b1;
    settle();
    chk("sr_req1",   dev_req,  1);
    chk("sr_addr",   dev_addr, 32'h100);
    chk("sr_we",     dev_we,   0);
    chk("sr_be",     dev_be,   4'hF);
    chk("sr_active", dbg_state, S_ACTIVE);
    next_cycle();
    dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'hDEADBEEF;
    settle();
    chk("sr_req2",   dev_req,  0);
    chk("sr_ack2",   wb_ack,   0);
    next_cycle();
    dev_quiet();
    settle();
    chk("sr_ack3",   wb_ack,   1);
    chk("sr_err3",   wb_err,   0);
    chk("sr_dat3",   wb_dat_o, 32'hDEADBEEF);
    chk("sr_cnt3",   dbg_cnt,  0);
    next_cycle();
    wb_quiet(1'b0);
    settle();
    chk("sr_ack4",   wb_ack,   0);
    chk("sr_hold4",  wb_dat_o, 32'hDEADBEEF);
    next_cycle();
    settle();
    chk("sr_idle",   dbg_state, S_IDLE);

    // ---- Pipelined writes, gnt tied high, rvalid 2 cycles after gnt -----------
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
    acks = 0; sent = 0; mcnt = 0; mreq = 1'b0; rv_prev = 1'b0;
    ghist = 2'b00; rd_seq = 32'hA000_0000;
    for (int c = 0; c < 30 && acks < 4; c++) begin
      dev_gnt    = 1'b1;
      dev_rvalid = ghist[1];
      dev_rdata  = ghist[1] ? rd_seq : 32'h0;
      if (ghist[1]) begin
        rd_q.push_back(rd_seq);
        rd_seq = rd_seq + 32'h1;
      end
      if (sent < 4) wb_put(1'b1, 4'hF, 32'h40 + 32'(4 * sent), 32'(sent + 1));
      else          wb_quiet(1'b1);
      settle();
      chk("pw_stall", wb_stall, (mcnt == 2));
      chk("pw_req",   dev_req,  mreq);
      chk("pw_ack",   wb_ack,   rv_prev);
      chk("pw_err",   wb_err,   0);
      if (rv_prev) begin
        if (rd_q.size() > 0) chk("pw_rdata", wb_dat_o, rd_q.pop_front());
        else                 chk("pw_rdata_q", 32'(rd_q.size()), 1);
        acks++;
      end
      if (mreq) begin
        if (exp_q.size() > 0) chk("pw_wdata", dev_wdata, exp_q.pop_front());
        else                  chk("pw_wdata_q", 32'(exp_q.size()), 1);
      end
      acc   = (sent < 4) && (mcnt != 2);
      mcnt  = mcnt + (acc ? 1 : 0) - (dev_rvalid ? 1 : 0);
      ghist = {ghist[0], mreq};
      mreq  = acc;
      rv_prev = dev_rvalid;
      if (acc) sent++;
      next_cycle();
    end
    chk("pw_acks",   32'(acks), 4);
    chk("pw_wleft",  32'(exp_q.size()), 0);
    wb_quiet(1'b0); dev_quiet();
    settle();
    chk("pw_cnt",    dbg_cnt, 0);
    next_cycle();
    settle();
    chk("pw_idle",   dbg_state, S_IDLE);
    next_cycle();

    // ---- Grant backpressure --------------------------------------------------
    wb_put(1'b0, 4'hF, 32'h200, 32'h0);
    settle();
    chk("gb_stall0", wb_stall, 0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      wb_put(1'b0, 4'hF, 32'h204, 32'h0);
      dev_gnt = 1'b0;
      settle();
      chk("gb_req",   dev_req,  1);
      chk("gb_addr",  dev_addr, 32'h200);
      chk("gb_stall", wb_stall, 1);
      next_cycle();
    end
    dev_gnt = 1'b1;
    settle();
    chk("gb_stall_g", wb_stall, 0);
    chk("gb_addr_g",  dev_addr, 32'h200);
    next_cycle();
    wb_quiet(1'b1);
    settle();
    chk("gb_req2",   dev_req,  1);
    chk("gb_addr2",  dev_addr, 32'h204);
    chk("gb_cnt2",   dbg_cnt,  2);
    chk("gb_full",   wb_stall, 1);
    next_cycle();
    dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h11;
    settle();
    chk("gb_req3",   dev_req,  0);
    next_cycle();
    dev_rdata = 32'h22;
    settle();
    chk("gb_ack1",   wb_ack,   1);
    chk("gb_dat1",   wb_dat_o, 32'h11);
    next_cycle();
    dev_quiet(); wb_quiet(1'b0);
    settle();
    chk("gb_ack2",   wb_ack,   1);
    chk("gb_dat2",   wb_dat_o, 32'h22);
    chk("gb_cnt",    dbg_cnt,  0);
    next_cycle();
    settle();
    chk("gb_ack_end", wb_ack, 0);
    chk("gb_idle",   dbg_state, S_IDLE);
    next_cycle();

    // ---- Abort with two reads outstanding ------------------------------------
    wb_put(1'b0, 4'hF, 32'h300, 32'h0);
    next_cycle();
    wb_put(1'b0, 4'hF, 32'h304, 32'h0);
    dev_gnt = 1'b1;
    settle();
    chk("ab_stall1", wb_stall, 0);
    next_cycle();
    wb_quiet(1'b0); dev_gnt = 1'b0;
    settle();
    chk("ab_req2",   dev_req,  1);
    chk("ab_addr2",  dev_addr, 32'h304);
    next_cycle();
    dev_gnt = 1'b1; dev_rvalid = 1'b1; dev_rdata = 32'hAAAA;
    settle();
    chk("ab_drain",  dbg_state, S_DRAIN);
    chk("ab_stall",  wb_stall, 1);
    chk("ab_hold_req", dev_req, 1);
    chk("ab_cnt2",   dbg_cnt,  2);
    next_cycle();
    dev_gnt = 1'b0; dev_rdata = 32'hBBBB;
    settle();
    chk("ab_ack1",   wb_ack,   0);
    chk("ab_drain1", dbg_state, S_DRAIN);
    chk("ab_cnt1",   dbg_cnt,  1);
    next_cycle();
    dev_quiet();
    settle();
    chk("ab_ack2",   wb_ack,   0);
    chk("ab_err2",   wb_err,   0);
    chk("ab_idle",   dbg_state, S_IDLE);
    chk("ab_stall_i", wb_stall, 0);
    chk("ab_dat_hold", wb_dat_o, 32'h22);
    next_cycle();
    wb_put(1'b1, 4'h3, 32'h400, 32'hCAFE);
    settle();
    chk("ab_new_stall", wb_stall, 0);
    next_cycle();
    wb_quiet(1'b1); dev_gnt = 1'b1;
    settle();
    chk("ab_new_we",  dev_we,    1);
    chk("ab_new_be",  dev_be,    4'h3);
    chk("ab_new_wd",  dev_wdata, 32'hCAFE);
    next_cycle();
    dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h5;
    next_cycle();
    dev_quiet();
    settle();
    chk("ab_new_ack", wb_ack,   1);
    chk("ab_new_dat", wb_dat_o, 32'h5);
    next_cycle();
    wb_quiet(1'b0);
    next_cycle();

    // ---- Error response -------------------------------------------------------
    wb_put(1'b0, 4'hF, 32'h500, 32'h0);
    next_cycle();
    wb_quiet(1'b1); dev_gnt = 1'b1;
    next_cycle();
    dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_err = 1'b1; dev_rdata = 32'hBAD;
    next_cycle();
    dev_quiet();
    settle();
`ifdef WB2CORE_ERR_EN
    chk("er_err",    wb_err,   1);
    chk("er_ack",    wb_ack,   0);
`else
    chk("er_err",    wb_err,   0);
    chk("er_ack",    wb_ack,   1);
`endif
    chk("er_dat",    wb_dat_o, 32'hBAD);
    next_cycle();
    wb_quiet(1'b0);
    settle();
    chk("er_ack_end", wb_ack, 0);
    chk("er_err_end", wb_err, 0);
    next_cycle();

    // ---- Reset mid-transfer ---------------------------------------------------
    wb_put(1'b0, 4'hF, 32'h600, 32'h0);
    next_cycle();
    wb_put(1'b1, 4'h3, 32'h604, 32'h55);
    dev_gnt = 1'b1;
    settle();
    chk("rm_stall",  wb_stall, 0);
    next_cycle();
    wb_quiet(1'b1); dev_gnt = 1'b0;
    settle();
    chk("rm_req",    dev_req,   1);
    chk("rm_we",     dev_we,    1);
    chk("rm_be",     dev_be,    4'h3);
    chk("rm_wd",     dev_wdata, 32'h55);
    chk("rm_cnt",    dbg_cnt,   2);
    rst = 1'b1;
    #1;
    chk("rm_o_stall", wb_stall,  0);
    chk("rm_o_ack",   wb_ack,    0);
    chk("rm_o_err",   wb_err,    0);
    chk("rm_o_dat",   wb_dat_o,  0);
    chk("rm_o_req",   dev_req,   0);
    chk("rm_o_we",    dev_we,    0);
    chk("rm_o_be",    dev_be,    0);
    chk("rm_o_addr",  dev_addr,  0);
    chk("rm_o_wd",    dev_wdata, 0);
    chk("rm_o_cnt",   dbg_cnt,   0);
    chk("rm_o_state", dbg_state, S_IDLE);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    dev_rvalid = 1'b1; dev_rdata = 32'h77;
    settle();
    next_cycle();
    dev_quiet();
    settle();
    chk("rm_stray_ack", wb_ack,   0);
    chk("rm_stray_cnt", dbg_cnt,  0);
    chk("rm_stray_dat", wb_dat_o, 0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
